// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;

    // EX operand mux select encoding; 2'b00 is never produced.
    localparam logic [1:0] FWD_RF    = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b11;

    // Destination record carried by each shadow pipeline stage.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } dest_entry_t;

    localparam dest_entry_t DEST_BUBBLE = '0;

    // True when a stage will produce the register the ID instruction reads.
    // x0 is hard-wired zero and never forwarded.
    function automatic logic entry_match(
        input dest_entry_t           e,
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  rs_used,
        input logic                  id_valid
    );
        return e.valid & e.reg_write & (e.rd == rs) & (rs != '0) & rs_used & id_valid;
    endfunction

endpackage

// File: rtl/hazard_dest_pipe.sv
// Three-entry EX/MEM/WB shadow of in-flight destination registers.
// EX takes the ID entry or a bubble; MEM and WB always advance.
module hazard_dest_pipe
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  dest_entry_t id_entry_i,
    input  logic        bubble_i,
    output dest_entry_t ex_entry_o,
    output dest_entry_t mem_entry_o,
    output dest_entry_t wb_entry_o
);

    dest_entry_t ex_q, ex_d;
    dest_entry_t mem_q, mem_d;
    dest_entry_t wb_q, wb_d;

    // Next-state: shift the shadow pipeline, inserting a bubble into EX on request.
    always_comb begin
        ex_d  = id_entry_i;
        mem_d = ex_q;
        wb_d  = mem_q;
        if (bubble_i) begin
            ex_d = DEST_BUBBLE;
        end
    end

    // Stage registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= DEST_BUBBLE;
            mem_q <= DEST_BUBBLE;
            wb_q  <= DEST_BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_entry_o  = ex_q;
    assign mem_entry_o = mem_q;
    assign wb_entry_o  = wb_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for a 5-stage core.
// Selects are computed in ID and registered into EX; stall is combinational.
// Optional build macro HAZARD_STATS_EN adds 32-bit stall_count/flush_count.
module hazard_fwd_unit
    import hazard_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  branch_taken,
`ifdef HAZARD_STATS_EN
    output logic [31:0]           stall_count,
    output logic [31:0]           flush_count,
`endif
    output logic                  stall,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b
);

    dest_entry_t id_entry;
    dest_entry_t ex_entry;
    dest_entry_t mem_entry;
    dest_entry_t wb_entry;
    logic        bubble;
    logic        ex_match_a, ex_match_b;
    logic        mem_match_a, mem_match_b;
    logic [1:0]  sel_a_q, sel_a_d;
    logic [1:0]  sel_b_q, sel_b_d;

    assign id_entry = '{valid: id_valid, rd: id_rd, reg_write: id_reg_write,
                        mem_read: id_mem_read};

    hazard_dest_pipe u_dest_pipe (
        .clk         (clk),
        .rst         (rst),
        .id_entry_i  (id_entry),
        .bubble_i    (bubble),
        .ex_entry_o  (ex_entry),
        .mem_entry_o (mem_entry),
        .wb_entry_o  (wb_entry)
    );

    // Producer matches for both operands. The WB stage is absent on purpose:
    // the register file is write-first, so a WB producer reads correctly.
    always_comb begin
        ex_match_a  = entry_match(ex_entry,  id_rs1, id_rs1_used, id_valid);
        ex_match_b  = entry_match(ex_entry,  id_rs2, id_rs2_used, id_valid);
        mem_match_a = entry_match(mem_entry, id_rs1, id_rs1_used, id_valid);
        mem_match_b = entry_match(mem_entry, id_rs2, id_rs2_used, id_valid);
    end

    // Load-use stall, suppressed by a flush; either one injects an EX bubble.
    always_comb begin
        stall  = id_valid & ~branch_taken & ex_entry.mem_read & (ex_match_a | ex_match_b);
        bubble = stall | branch_taken;
    end

    // Next selects: the newest producer (EX) wins over the older one (MEM).
    // A load in EX always stalls, so it is only ever picked up from MEM/WB.
    always_comb begin
        sel_a_d = FWD_RF;
        sel_b_d = FWD_RF;
        if (!bubble) begin
            if (ex_match_a)       sel_a_d = FWD_EXMEM;
            else if (mem_match_a) sel_a_d = FWD_MEMWB;
            if (ex_match_b)       sel_b_d = FWD_EXMEM;
            else if (mem_match_b) sel_b_d = FWD_MEMWB;
        end
    end

    // Select registers that feed the EX operand muxes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_a_q <= FWD_RF;
            sel_b_q <= FWD_RF;
        end else begin
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

    assign fwd_sel_a = sel_a_q;
    assign fwd_sel_b = sel_b_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Event counters; they wrap naturally at 2^32.
    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, stall};
        flush_cnt_d = flush_cnt_q + {31'd0, branch_taken};
    end

    // Counter registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Table-driven bench for hazard_fwd_unit: one row per cycle, expected
// stall and registered selects observed in that cycle before the clock edge.
module tb_hazard_fwd_unit;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used;
    logic       id_reg_write, id_mem_read;
    logic       branch_taken;
    logic       stall;
    logic [1:0] fwd_sel_a, fwd_sel_b;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count, flush_count;
`endif

    int n_checks;
    int n_fails;

    hazard_fwd_unit dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .branch_taken (branch_taken),
`ifdef HAZARD_STATS_EN
        .stall_count  (stall_count),
        .flush_count  (flush_count),
`endif
        .stall        (stall),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       br;
        logic       rs;
        logic       e_stall;
        logic [1:0] e_a;
        logic [1:0] e_b;
    } vec_t;

    vec_t vecs[$];

    // Scoreboard: {stall, sel_a, sel_b}
    logic [4:0] exp_q[$];

    task automatic row(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic br, input logic rs,
                       input logic e_stall, input logic [1:0] e_a, input logic [1:0] e_b);
        vec_t r;
        r.v = v; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2; r.rd = rd;
        r.rw = rw; r.mr = mr; r.br = br; r.rs = rs;
        r.e_stall = e_stall; r.e_a = e_a; r.e_b = e_b;
        vecs.push_back(r);
    endtask

    task automatic idle_row(input logic [1:0] e_a, input logic [1:0] e_b);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_a, e_b);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input vec_t r);
        rst          = r.rs;
        id_valid     = r.v;
        id_rs1       = r.rs1;
        id_rs1_used  = r.u1;
        id_rs2       = r.rs2;
        id_rs2_used  = r.u2;
        id_rd        = r.rd;
        id_reg_write = r.rw;
        id_mem_read  = r.mr;
        branch_taken = r.br;
    endtask

    task automatic check_bit(input string name, input int idx, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s row %0d: got %b expected %b", name, idx, act, req);
        end
    endtask

    task automatic check_sel(input string name, input int idx, input logic [1:0] act, input logic [1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s row %0d: got %b expected %b", name, idx, act, req);
        end
    endtask

    task automatic check_cnt(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [4:0] e;
        n_checks = 0;
        n_fails  = 0;

        //   v  rs1 u1 rs2 u2 rd rw mr br rst  stall a      b
        idle_row(2'b01, 2'b01);                               // 0 reset state
        idle_row(2'b01, 2'b01);                               // 1 idle
        // ADD x5 then SUB rs1=x5 -> EX/MEM forward on a
        row(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 2'b01, 2'b01);   // 2
        row(1, 5, 1, 6, 1, 8, 1, 0, 0, 0, 0, 2'b01, 2'b01);   // 3
        idle_row(2'b10, 2'b01);                               // 4
        // ADD x5, NOP, rs2=x5 -> MEM/WB forward on b
        row(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 2'b01, 2'b01);   // 5
        idle_row(2'b01, 2'b01);                               // 6
        row(1, 3, 1, 5, 1, 9, 1, 0, 0, 0, 0, 2'b01, 2'b01);   // 7
        idle_row(2'b01, 2'b11);                               // 8
        // LW x7 then rs1=x7 -> one stall, bubble, then 11
        row(1, 2, 1, 0, 0, 7, 1, 1, 0, 0, 0, 2'b01, 2'b01);   // 9
        row(1, 7, 1, 4, 1, 10, 1, 0, 0, 0, 1, 2'b01, 2'b01);  // 10 stall
        row(1, 7, 1, 4, 1, 10, 1, 0, 0, 0, 0, 2'b01, 2'b01);  // 11 held, bubble visible
        idle_row(2'b11, 2'b01);                               // 12
        // write x0, consumer of x0
        row(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b01);   // 13
        row(1, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 2'b01, 2'b01);   // 14
        idle_row(2'b01, 2'b01);                               // 15
        // LW x7 + consumer + branch_taken: flush beats stall
        row(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 2'b01, 2'b01);   // 16
        row(1, 7, 1, 7, 1, 11, 1, 0, 1, 0, 0, 2'b01, 2'b01);  // 17 flush
        row(1, 11, 1, 7, 1, 1, 1, 0, 0, 0, 0, 2'b01, 2'b01);  // 18 EX bubble, LW in MEM
        idle_row(2'b01, 2'b11);                               // 19
        // back-to-back producers of x12: EX wins
        row(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0, 2'b01, 2'b01);  // 20
        row(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0, 2'b01, 2'b01);  // 21
        row(1, 12, 1, 12, 1, 2, 1, 0, 0, 0, 0, 2'b01, 2'b01); // 22
        idle_row(2'b10, 2'b10);                               // 23
        // rs1 not used
        row(1, 0, 0, 0, 0, 13, 1, 0, 0, 0, 0, 2'b01, 2'b01);  // 24
        row(1, 13, 0, 13, 1, 3, 1, 0, 0, 0, 0, 2'b01, 2'b01); // 25
        idle_row(2'b01, 2'b10);                               // 26
        // invalid ID never forwards
        row(1, 0, 0, 0, 0, 14, 1, 0, 0, 0, 0, 2'b01, 2'b01);  // 27
        row(0, 14, 1, 14, 1, 3, 1, 0, 0, 0, 0, 2'b01, 2'b01); // 28
        idle_row(2'b01, 2'b01);                               // 29
        // invalid ID never stalls
        row(1, 0, 0, 0, 0, 15, 1, 1, 0, 0, 0, 2'b01, 2'b01);  // 30
        row(0, 15, 1, 0, 0, 3, 1, 0, 0, 0, 0, 2'b01, 2'b01);  // 31
        idle_row(2'b01, 2'b01);                               // 32
        // load already in MEM: no stall, 11 on b
        row(1, 0, 0, 0, 0, 16, 1, 1, 0, 0, 0, 2'b01, 2'b01);  // 33
        idle_row(2'b01, 2'b01);                               // 34
        row(1, 1, 1, 16, 1, 3, 1, 0, 0, 0, 0, 2'b01, 2'b01);  // 35
        idle_row(2'b01, 2'b11);                               // 36
        // mid-stream reset clears EX producer and selects
        row(1, 0, 0, 0, 0, 17, 1, 0, 0, 0, 0, 2'b01, 2'b01);  // 37
        row(1, 17, 1, 0, 0, 3, 1, 0, 0, 1, 0, 2'b01, 2'b01);  // 38 rst
        row(1, 17, 1, 0, 0, 3, 1, 0, 0, 0, 0, 2'b01, 2'b01);  // 39
        idle_row(2'b01, 2'b01);                               // 40

        // reset
        drive(vecs[0]);
        rst = 1'b1;
        repeat (3) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            exp_q.push_back({vecs[i].e_stall, vecs[i].e_a, vecs[i].e_b});
`ifdef HAZARD_STATS_EN
            if (i == 0) begin
                check_cnt("stall_count_reset", stall_count, 32'd0);
                check_cnt("flush_count_reset", flush_count, 32'd0);
            end
            if (i == 37) begin
                check_cnt("stall_count", stall_count, 32'd1);
                check_cnt("flush_count", flush_count, 32'd1);
            end
            if (i == 39) begin
                check_cnt("stall_count_midreset", stall_count, 32'd0);
                check_cnt("flush_count_midreset", flush_count, 32'd0);
            end
`endif
            #2;
            e = exp_q.pop_front();
            check_bit("stall", i, stall, e[4]);
            check_sel("fwd_sel_a", i, fwd_sel_a, e[3:2]);
            check_sel("fwd_sel_b", i, fwd_sel_b, e[1:0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
